// File: rtl/lab2_pkg.sv
// Shared constants and types for the lab2 response checker.
// Truth table bit i is circuit output for vec == i.
package lab2_pkg;

  localparam int VEC_W = 4;

  localparam logic [15:0] LAB2_CIRC2_TT =
    16'b0001_0010_1101_0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lab2_gates.sv
// Primitive gate cells shared by the lab2 netlists.
// Each cell is a single combinational function.
module xor_i2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module and_i2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module and_i3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = a & b & c;
endmodule

module or_i2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// File: rtl/lab2_golden.sv
// Golden lab2 circuit built from the gate cells:
// s = (~c & (b ^ d)) | (~a & b & c), vec = {a,b,c,d}.
module lab2_golden
  import lab2_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp
);

  logic nc;
  logic na;
  logic bxd;
  logic t0;
  logic t1;

  // Inverters are xor-with-one so only the gate set is used.
  xor_i2 u_nc (.a(vec[1]), .b(1'b1), .y(nc));
  xor_i2 u_na (.a(vec[3]), .b(1'b1), .y(na));
  xor_i2 u_bd (.a(vec[2]), .b(vec[0]), .y(bxd));

  and_i2 u_t0 (.a(nc), .b(bxd), .y(t0));
  and_i3 u_t1 (
    .a(na),
    .b(vec[2]),
    .c(vec[1]),
    .y(t1)
  );

  or_i2 u_s (.a(t0), .b(t1), .y(exp));

endmodule

// File: rtl/lab2_resp_checker.sv
// Response checker: compares DUT output to the golden model,
// tracks errors, first failure and per-vector coverage.
module lab2_resp_checker
  import lab2_pkg::*;
#(
  parameter int ERR_W      = 5,
  parameter int MAX_CHECKS = 32,
  parameter int CHK_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_exp,
  output logic [15:0]      cov_map,
  output logic [CHK_W-1:0] chk_count
);

  state_e state_q, state_d;

  logic [ERR_W-1:0] err_q, err_d;
  logic [CHK_W-1:0] chk_q, chk_d;
  logic [15:0]      cov_q, cov_d;
  logic             to_q, to_d;
  logic             ffv_q, ffv_d;
  logic [VEC_W-1:0] ffvec_q, ffvec_d;
  logic             ffexp_q, ffexp_d;

  logic             exp;
  logic             chk_en;
  logic             mism;
  logic [15:0]      cov_set;
  logic [CHK_W-1:0] chk_inc;
  logic             full;
  logic             lim;

  lab2_golden u_gold (
    .vec(vec),
    .exp(exp)
  );

  // A same-cycle start always wins over the check.
  assign chk_en  = (state_q == ST_RUN)
                 & vec_valid & ~start;
  assign mism    = (dut_out !== exp);
  assign cov_set = cov_q | (16'(1) << vec);
  assign full    = &cov_set;
  assign chk_inc = (&chk_q) ? chk_q
                 : chk_q + CHK_W'(1);
  assign lim     = (chk_inc == CHK_W'(MAX_CHECKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (chk_en && (full || lim))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    pass = done & ~to_q & (err_q == '0);
  end

  always_comb begin
    err_d   = err_q;
    chk_d   = chk_q;
    cov_d   = cov_q;
    to_d    = to_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    ffexp_d = ffexp_q;
    if (start) begin
      err_d   = '0;
      chk_d   = '0;
      cov_d   = '0;
      to_d    = 1'b0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
      ffexp_d = 1'b0;
    end else if (chk_en) begin
      cov_d = cov_set;
      chk_d = chk_inc;
      if (mism) begin
        if (!(&err_q)) err_d = err_q + ERR_W'(1);
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec;
          ffexp_d = exp;
        end
      end
      // Full coverage takes priority over the check limit.
      if (!full && lim) to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      chk_q   <= '0;
      cov_q   <= '0;
      to_q    <= 1'b0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      ffexp_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      chk_q   <= chk_d;
      cov_q   <= cov_d;
      to_q    <= to_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      ffexp_q <= ffexp_d;
    end
  end

  assign timeout          = to_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_exp   = ffexp_q;
  assign cov_map          = cov_q;
  assign chk_count        = chk_q;

endmodule
